rv32imf_prefetch_buffer: RTL and testbench

- Instruction prefetch stage directly upstream of the instruction aligner in the IF stage.
- Issues word-aligned OBI-style requests to instruction memory and queues returned words in a small FIFO.
- Presents one 32-bit word per handshake as fetch_valid_o/fetch_rdata_o, which the aligner consumes.
- On branch_i: flushes the FIFO, drops in-flight responses and redirects fetching to the branch target.

---
 rtl/rv32imf_prefetch_buffer.sv | 137 +++++++++++++
 tb/tb_rv32imf_prefetch_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rv32imf_prefetch_buffer.sv
// rv32imf_prefetch_buffer
//   Instruction prefetch stage feeding the IF-stage aligner. Issues word-aligned
//   OBI requests, queues returned words in a small FIFO and offers one word per
//   handshake. A branch flushes the FIFO, discards in-flight responses and
//   redirects fetching.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_i             fetch enable (gates new requests only)
//   branch_i          redirect strobe, branch_addr_i target (bits [1:0] ignored)
//   fetch_ready_i     aligner accepts the offered word
//   fetch_valid_o     word available, fetch_rdata_o the word
//   instr_req_o/gnt_i/addr_o          OBI address phase
//   instr_rvalid_i/rdata_i            OBI response phase
//   busy_o            transaction outstanding or request pending
module rv32imf_prefetch_buffer #(
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fetch_ready_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_rdata_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = 5;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] fifo_cnt_q;
  logic [OW-1:0] outst_q, discard_q, outst_nxt;
  logic [31:0]   next_addr_q, redir_addr_q, branch_tgt;
  logic          pend_q, redir_q;

  logic          fifo_empty, req_gnt, rsp_keep, accept, push, pop;
  logic [SW-1:0] credit_used;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^branch_addr_i[1:0];
  assign branch_tgt       = {branch_addr_i[31:2], 2'b00};

  assign fifo_empty  = (fifo_cnt_q == '0);
  // FIFO slots already promised: stored words plus live (non-discarded) responses
  assign credit_used = SW'(fifo_cnt_q) + SW'(outst_q) - SW'(discard_q);

  // pend_q keeps an ungranted request asserted regardless of req_i or credits
  assign instr_req_o  = pend_q |
                        (req_i & (outst_q < OW'(MAX_OUTSTANDING)) &
                         (credit_used < SW'(FIFO_DEPTH)));
  assign instr_addr_o = next_addr_q;
  assign req_gnt      = instr_req_o & instr_gnt_i;
  assign outst_nxt    = outst_q + OW'(req_gnt) - OW'(instr_rvalid_i);
  assign busy_o       = (outst_q != '0) | instr_req_o;

  assign rsp_keep      = instr_rvalid_i & (discard_q == '0) & ~branch_i;
  assign fetch_valid_o = fifo_empty ? rsp_keep : ~branch_i;
  assign fetch_rdata_o = fifo_empty ? instr_rdata_i : fifo_mem[rd_ptr_q];
  assign accept        = fetch_valid_o & fetch_ready_i;
  // a bypassed word that is taken right away never enters the FIFO
  assign push          = rsp_keep & ~(fifo_empty & accept);
  assign pop           = ~fifo_empty & accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q      <= '0;
      discard_q    <= '0;
      pend_q       <= 1'b0;
      redir_q      <= 1'b0;
      redir_addr_q <= '0;
      next_addr_q  <= '0;
    end else begin
      outst_q <= outst_nxt;
      pend_q  <= instr_req_o & ~instr_gnt_i;

      if (branch_i) begin
        // a still-pending request completes at its old address; the one
        // extra discard for it is added when it is granted
        discard_q <= outst_nxt;
      end else begin
        discard_q <= discard_q - OW'(instr_rvalid_i & (discard_q != '0))
                               + OW'(redir_q & req_gnt);
      end

      if (branch_i) begin
        if (instr_req_o & ~instr_gnt_i) begin
          redir_q      <= 1'b1;
          redir_addr_q <= branch_tgt;
        end else begin
          redir_q     <= 1'b0;
          next_addr_q <= branch_tgt;
        end
      end else if (req_gnt) begin
        if (redir_q) begin
          redir_q     <= 1'b0;
          next_addr_q <= redir_addr_q;
        end else begin
          next_addr_q <= next_addr_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (branch_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // storage needs no reset: fifo_cnt_q qualifies every read
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= instr_rdata_i;
  end

endmodule

// File: tb/tb_rv32imf_prefetch_buffer.sv
// Testbench for rv32imf_prefetch_buffer: OBI memory model with configurable
// response latency, scoreboard of expected fetch words and expected request
// addresses.
module tb_rv32imf_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, branch_i, fetch_ready_i, instr_gnt_i, instr_rvalid_i;
  logic [31:0] branch_addr_i, instr_rdata_i;
  logic        fetch_valid_o, instr_req_o, busy_o;
  logic [31:0] fetch_rdata_o, instr_addr_o;

  always #5 clk = ~clk;

  rv32imf_prefetch_buffer #(.FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .fetch_ready_i(fetch_ready_i),
    .fetch_valid_o(fetch_valid_o), .fetch_rdata_o(fetch_rdata_o),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
    .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          cyc;
  } txn_t;

  txn_t        mem_q[$];
  logic [31:0] exp_q[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, resp_lat = 1, grants = 0;
  bit          req_en = 0, rdy_en = 0, gnt_en = 1;
  logic [31:0] exp_addr = '0, redir_tgt = '0, prev_addr = '0;
  bit          redir = 0, stale_next = 0, prev_pend = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_C3F0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0; fetch_ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    req_en = 0;
    mem_q.delete(); exp_q.delete();
    exp_addr = '0; redir = 0; stale_next = 0; prev_pend = 0;
    #1;
    check_eq("rst_valid", fetch_valid_o, 0);
    check_eq("rst_req",   instr_req_o,   0);
    check_eq("rst_addr",  instr_addr_o,  0);
    check_eq("rst_busy",  busy_o,        0);
    check_eq("rst_rdata", fetch_rdata_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at negedge, sample 2ns later (before posedge).
  task automatic step(input bit b, input logic [31:0] tgt);
    txn_t        t;
    bit          rv;
    logic [31:0] tgt_al;
    @(negedge clk);
    cyc++;
    tgt_al        = {tgt[31:2], 2'b00};
    req_i         = req_en;
    fetch_ready_i = rdy_en;
    instr_gnt_i   = gnt_en;
    branch_i      = b;
    branch_addr_i = tgt;
    if (b) begin
      for (int i = 0; i < mem_q.size(); i++) mem_q[i].stale = 1'b1;
      exp_q.delete();
    end
    rv = (mem_q.size() > 0) && (cyc >= mem_q[0].cyc + resp_lat);
    if (rv) begin
      t = mem_q.pop_front();
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mem_word(t.addr);
      if (!t.stale) exp_q.push_back(mem_word(t.addr));
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = $urandom;
    end
    #2;
    if (prev_pend) begin
      check_eq("req_hold",  instr_req_o,  1);
      check_eq("addr_hold", instr_addr_o, prev_addr);
    end
    check_eq("valid", fetch_valid_o, (exp_q.size() > 0) && !b);
    if (fetch_valid_o && exp_q.size() > 0) begin
      check_eq("rdata", fetch_rdata_o, exp_q[0]);
      if (fetch_ready_i) void'(exp_q.pop_front());
    end
    check_eq("busy", busy_o, (mem_q.size() != 0) || rv || instr_req_o);
    if (instr_req_o && instr_gnt_i) begin
      grants++;
      check_eq("gnt_addr", instr_addr_o, exp_addr);
      t.addr = instr_addr_o; t.stale = b || stale_next; t.cyc = cyc;
      mem_q.push_back(t);
      stale_next = 0;
      if (b) begin
        exp_addr = tgt_al; redir = 0;
      end else if (redir) begin
        exp_addr = redir_tgt; redir = 0;
      end else begin
        exp_addr = exp_addr + 32'd4;
      end
    end else if (instr_req_o && b) begin
      stale_next = 1; redir = 1; redir_tgt = tgt_al;
    end else if (b) begin
      exp_addr = tgt_al; redir = 0;
    end
    prev_pend = instr_req_o && !instr_gnt_i;
    prev_addr = instr_addr_o;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  initial begin
    do_reset();

    // streaming from 0 with bypass
    req_en = 1; rdy_en = 1; gnt_en = 1; resp_lat = 1;
    run(8);

    // aligner stalled: two credits, then requests stop
    do_reset();
    req_en = 1; rdy_en = 0; grants = 0;
    run(6);
    check_eq("full_grants", grants, 2);
    check_eq("full_noreq",  instr_req_o, 0);
    check_eq("full_valid",  fetch_valid_o, 1);
    rdy_en = 1;
    run(6);

    // branch with two outstanding, target bits [1:0] ignored
    resp_lat = 2;
    run(4);
    step(1'b1, 32'h0000_1006);
    run(8);

    // branch onto a pending ungranted request
    resp_lat = 1; req_en = 0;
    run(4);
    step(1'b1, 32'h0000_0020);
    gnt_en = 0; req_en = 1;
    run(3);
    check_eq("pend_addr", instr_addr_o, 32'h20);
    req_en = 0;
    step(1'b1, 32'h0000_0040);
    run(2);
    check_eq("pend_addr2", instr_addr_o, 32'h20);
    gnt_en = 1; req_en = 1;
    run(6);

    // branch coinciding with rvalid and gnt
    run(3);
    step(1'b1, 32'h0000_0300);
    run(5);

    // address wrap
    step(1'b1, 32'hFFFF_FFF8);
    run(6);

    // random ready / grant / branches
    resp_lat = 2;
    for (int i = 0; i < 300; i++) begin
      rdy_en = ($urandom_range(0, 3) != 0);
      gnt_en = ($urandom_range(0, 3) != 0);
      req_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) step(1'b1, $urandom);
      else                            step(1'b0, 32'h0);
    end

    // drain
    req_en = 0; rdy_en = 1; gnt_en = 1;
    run(10);
    check_eq("drain_exp", exp_q.size(), 0);
    check_eq("drain_mem", mem_q.size(), 0);
    check_eq("drain_busy", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
